// File: rtl/adc_buf_pkg.sv
// Shared types and helpers for the ADC sample buffer write controller.
package adc_buf_pkg;

    localparam int BUF_WORD_WIDTH = 32;
    localparam int HALF_WORD      = BUF_WORD_WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } buf_state_t;

    // Channel id in the upper half-word, sample in the lower, both zero-extended by the caller.
    function automatic logic [BUF_WORD_WIDTH-1:0] pack_wdata(
        input logic [HALF_WORD-1:0] chid,
        input logic [HALF_WORD-1:0] data
    );
        return {chid, data};
    endfunction

endpackage

// File: rtl/adc_buf_ctrl_adc_sample_filter.sv
// Combinational sample qualification: channel range, live mask and trigger-channel match.
module adc_sample_filter #(
    parameter int ADC_NUM_CHS    = 8,
    parameter int ADC_CHID_WIDTH = 4
) (
    input  logic                      valid_i,
    input  logic [ADC_CHID_WIDTH-1:0] chid_i,
    input  logic [ADC_NUM_CHS-1:0]    ch_mask_i,
    input  logic [ADC_CHID_WIDTH-1:0] trig_chid_i,
    output logic                      sample_ok_o,
    output logic                      trig_hit_o
);

    logic [ADC_NUM_CHS-1:0] ch_hit;

    // One decoder per channel; ids at or above ADC_NUM_CHS match no entry and are dropped.
    generate
        for (genvar gi = 0; gi < ADC_NUM_CHS; gi++) begin : g_ch
            assign ch_hit[gi] = (chid_i == ADC_CHID_WIDTH'(gi)) && ch_mask_i[gi];
        end
    endgenerate

    assign sample_ok_o = valid_i && (|ch_hit);
    assign trig_hit_o  = sample_ok_o && (chid_i == trig_chid_i);

endmodule

// File: rtl/adc_buf_ctrl.sv
// Write-side controller: filters ADC samples and writes them into a linear or circular buffer region.
module adc_buf_ctrl
    import adc_buf_pkg::*;
#(
    parameter int ADC_NUM_CHS    = 8,
    parameter int ADC_CHID_WIDTH = 4,
    parameter int ADC_DATA_WIDTH = 16,
    parameter int BUF_AWIDTH     = 10,
    parameter int BUF_TRANS_SIZE = 10
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [BUF_AWIDTH-1:0]     cfg_buf_startaddr_i,
    input  logic [BUF_TRANS_SIZE-1:0] cfg_buf_size_i,
    input  logic [BUF_TRANS_SIZE-1:0] cfg_buf_flevel_i,
    input  logic                      cfg_buf_continuous_i,
    input  logic                      cfg_buf_en_i,
    input  logic                      cfg_buf_clr_i,
    input  logic [ADC_NUM_CHS-1:0]    cfg_buf_ch_mask_i,
    input  logic                      cfg_buf_en_mode_i,
    input  logic [ADC_CHID_WIDTH-1:0] cfg_buf_en_chid_i,
    input  logic                      adc_valid_i,
    input  logic [ADC_CHID_WIDTH-1:0] adc_chid_i,
    input  logic [ADC_DATA_WIDTH-1:0] adc_data_i,
    output logic                      buf_we_o,
    output logic [BUF_AWIDTH-1:0]     buf_addr_o,
    output logic [BUF_WORD_WIDTH-1:0] buf_wdata_o,
    output logic                      cfg_buf_en_o,
    output logic [BUF_AWIDTH-1:0]     cfg_buf_curr_addr_o,
    output logic [BUF_TRANS_SIZE-1:0] cfg_buf_bytes_left_o,
    output logic                      evt_flevel_o,
    output logic                      evt_done_o
);

    buf_state_t                state_reg;
    logic [BUF_AWIDTH-1:0]     curr_addr_reg;
    logic [BUF_TRANS_SIZE-1:0] left_reg;
    logic [BUF_TRANS_SIZE-1:0] written_reg;
    logic [BUF_TRANS_SIZE-1:0] flevel_reg;
    logic                      cont_reg;
    logic [ADC_CHID_WIDTH-1:0] trig_chid_reg;

    logic                      buf_we_reg;
    logic [BUF_AWIDTH-1:0]     buf_addr_reg;
    logic [BUF_WORD_WIDTH-1:0] buf_wdata_reg;
    logic                      evt_flevel_reg;
    logic                      evt_done_reg;

    logic                      sample_ok;
    logic                      trig_hit;
    logic                      accept;
    logic                      last_word;
    logic [BUF_TRANS_SIZE-1:0] written_inc;
    logic [BUF_AWIDTH-1:0]     addr_inc;

    adc_sample_filter #(
        .ADC_NUM_CHS    (ADC_NUM_CHS),
        .ADC_CHID_WIDTH (ADC_CHID_WIDTH)
    ) u_filter (
        .valid_i     (adc_valid_i),
        .chid_i      (adc_chid_i),
        .ch_mask_i   (cfg_buf_ch_mask_i),
        .trig_chid_i (trig_chid_reg),
        .sample_ok_o (sample_ok),
        .trig_hit_o  (trig_hit)
    );

    // A clear in the same cycle kills the sample, so no strobe is ever issued for it.
    assign accept = !cfg_buf_clr_i &&
                    (((state_reg == ST_RUN) && sample_ok) ||
                     ((state_reg == ST_ARMED) && trig_hit));

    assign last_word   = (left_reg == BUF_TRANS_SIZE'(1));
    assign written_inc = written_reg + BUF_TRANS_SIZE'(1);
    assign addr_inc    = curr_addr_reg + BUF_AWIDTH'(1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg      <= ST_IDLE;
            curr_addr_reg  <= '0;
            left_reg       <= '0;
            written_reg    <= '0;
            flevel_reg     <= '0;
            cont_reg       <= 1'b0;
            trig_chid_reg  <= '0;
            buf_we_reg     <= 1'b0;
            buf_addr_reg   <= '0;
            buf_wdata_reg  <= '0;
            evt_flevel_reg <= 1'b0;
            evt_done_reg   <= 1'b0;
        end else begin
            buf_we_reg     <= 1'b0;
            buf_addr_reg   <= '0;
            buf_wdata_reg  <= '0;
            evt_flevel_reg <= 1'b0;
            evt_done_reg   <= 1'b0;

            if (cfg_buf_clr_i) begin
                state_reg <= ST_IDLE;
                left_reg  <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cfg_buf_en_i && (cfg_buf_size_i != '0)) begin
                            curr_addr_reg <= cfg_buf_startaddr_i;
                            left_reg      <= cfg_buf_size_i;
                            written_reg   <= '0;
                            flevel_reg    <= cfg_buf_flevel_i;
                            cont_reg      <= cfg_buf_continuous_i;
                            trig_chid_reg <= cfg_buf_en_chid_i;
                            state_reg     <= cfg_buf_en_mode_i ? ST_ARMED : ST_RUN;
                        end
                    end
                    ST_ARMED, ST_RUN: begin
                        if (accept) begin
                            buf_we_reg     <= 1'b1;
                            buf_addr_reg   <= curr_addr_reg;
                            buf_wdata_reg  <= pack_wdata(HALF_WORD'(adc_chid_i),
                                                         HALF_WORD'(adc_data_i));
                            evt_flevel_reg <= (flevel_reg != '0) && (written_inc == flevel_reg);
                            if (last_word) begin
                                evt_done_reg <= 1'b1;
                                // Reload from the live config; a zero size cannot sustain a run.
                                if (cont_reg && (cfg_buf_size_i != '0)) begin
                                    curr_addr_reg <= cfg_buf_startaddr_i;
                                    left_reg      <= cfg_buf_size_i;
                                    written_reg   <= '0;
                                    flevel_reg    <= cfg_buf_flevel_i;
                                    cont_reg      <= cfg_buf_continuous_i;
                                    state_reg     <= ST_RUN;
                                end else begin
                                    curr_addr_reg <= addr_inc;
                                    left_reg      <= '0;
                                    written_reg   <= written_inc;
                                    state_reg     <= ST_IDLE;
                                end
                            end else begin
                                curr_addr_reg <= addr_inc;
                                left_reg      <= left_reg - BUF_TRANS_SIZE'(1);
                                written_reg   <= written_inc;
                                state_reg     <= ST_RUN;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign buf_we_o             = buf_we_reg;
    assign buf_addr_o           = buf_addr_reg;
    assign buf_wdata_o          = buf_wdata_reg;
    assign evt_flevel_o         = evt_flevel_reg;
    assign evt_done_o           = evt_done_reg;
    assign cfg_buf_en_o         = (state_reg != ST_IDLE);
    assign cfg_buf_curr_addr_o  = curr_addr_reg;
    assign cfg_buf_bytes_left_o = left_reg;

endmodule

// File: doc/adc_buf_ctrl.md
Name: adc_buf_ctrl

Overview:
- Write-side controller for the ADC sample buffer, directly downstream of the ADC register interface.
- Consumes the buffer configuration (start address, size, fill level, continuous, enable/clear pulses, channel mask, trigger mode/channel id).
- Filters incoming ADC samples and writes them to the buffer SRAM as a linear or circular region.
- Returns status (enable, current address, words left) to the register interface and raises fill-level and done events.

Parameters:
- ADC_NUM_CHS, 8, number of ADC channels
- ADC_CHID_WIDTH, 4, channel id width
- ADC_DATA_WIDTH, 16, sample width
- BUF_AWIDTH, 10, buffer word-address width
- BUF_TRANS_SIZE, 10, transfer size / fill-level width, in words

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_buf_startaddr_i  in  BUF_AWIDTH  region start word address
- cfg_buf_size_i  in  BUF_TRANS_SIZE  region length, words
- cfg_buf_flevel_i  in  BUF_TRANS_SIZE  fill-level threshold; 0 disables the event
- cfg_buf_continuous_i  in  1  reload on completion
- cfg_buf_en_i  in  1  start pulse
- cfg_buf_clr_i  in  1  abort pulse
- cfg_buf_ch_mask_i  in  ADC_NUM_CHS  per-channel accept mask
- cfg_buf_en_mode_i  in  1  1 = arm and wait for trigger channel
- cfg_buf_en_chid_i  in  ADC_CHID_WIDTH  trigger channel id
- adc_valid_i  in  1  sample strobe (no backpressure)
- adc_chid_i  in  ADC_CHID_WIDTH  sample channel id
- adc_data_i  in  ADC_DATA_WIDTH  sample value
- buf_we_o  out  1  buffer write strobe
- buf_addr_o  out  BUF_AWIDTH  buffer write address
- buf_wdata_o  out  32  {(16-ADC_CHID_WIDTH)'0, chid, (16-ADC_DATA_WIDTH)'0, data}
- cfg_buf_en_o  out  1  status: 1 in ARMED or RUN
- cfg_buf_curr_addr_o  out  BUF_AWIDTH  next write address
- cfg_buf_bytes_left_o  out  BUF_TRANS_SIZE  words remaining
- evt_flevel_o  out  1  one-cycle pulse at the fill threshold
- evt_done_o  out  1  one-cycle pulse at region completion

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal counters 0.
- FSM states: IDLE, ARMED, RUN.
- Sample accepted when all of the following hold:
  - adc_valid_i = 1
  - adc_chid_i < ADC_NUM_CHS
  - cfg_buf_ch_mask_i[adc_chid_i] = 1
  - FSM is in RUN
- An accepted sample produces buf_we_o=1, the current address, and packed data on the next cycle (1-cycle registered latency). Outputs are held 0 when not writing.
- IDLE:
  - cfg_buf_en_i with cfg_buf_size_i != 0 loads curr_addr = startaddr, left = size, written = 0.
  - Next state is ARMED if en_mode=1, otherwise RUN.
  - cfg_buf_en_i with size 0 is ignored.
- ARMED:
  - A valid sample from the trigger channel (chid == en_chid, mask bit set) moves the FSM to RUN.
  - The triggering sample itself is accepted and written in that same transition.
- RUN, each accepted sample:
  - curr_addr += 1, wrapping modulo 2^BUF_AWIDTH.
  - left -= 1; written += 1.
  - When written reaches flevel (flevel != 0): evt_flevel_o pulses in the same cycle as the write strobe.
- Last word (left 1→0):
  - evt_done_o pulses together with the write strobe.
  - If continuous: reload addr/left/written from the config inputs and stay in RUN. No re-trigger is needed.
  - Otherwise: go to IDLE; curr_addr holds last+1 and left holds 0.
- cfg_buf_clr_i:
  - Highest priority, in any state: go to IDLE next cycle, left = 0, no events.
  - A write strobe for a sample accepted in the clr cycle is suppressed.
- cfg_buf_clr_i and cfg_buf_en_i in the same cycle: clr wins; en is ignored.
- cfg_buf_en_i while in ARMED or RUN: ignored; no restart.
- Config inputs other than the en/clr pulses are sampled only at start or reload. Changes mid-run take effect at the next reload.
- cfg_buf_ch_mask_i is live, evaluated every cycle.
- Asynchronous reset mid-run: everything returns to reset values immediately; no pending write survives.

Decomposition:
- Shared package adc_buf_pkg holds:
  - the FSM state typedef (IDLE/ARMED/RUN)
  - the wdata packing function
  - the localparam for the 32-bit buffer word width
- One natural sub-module: adc_sample_filter. It is combinational mask/chid-range/trigger-match logic producing accept and trigger signals.
- The address/count datapath stays in the top module.

Test Plan:
- Linear fill: start=0x010, size=4, flevel=2, mode=0, mask=0xFF; 4 samples on ch3 → writes at 0x010..0x013; evt_flevel with the 2nd write; evt_done with the 4th; status en=0, curr=0x014, left=0.
- Trigger: en_mode=1, en_chid=5; samples on ch2, ch2, ch5, ch1 → first write is ch5's data at startaddr, then ch1; status en=1 while ARMED.
- Mask: mask=0x0F; samples on ch4..ch7 → no writes; samples on ch0..ch3 → writes; chid=9 never written.
- Continuous + wrap: start=0x3FE, size=4, continuous=1; 8 samples → addresses 3FE,3FF,000,001,3FE,3FF,000,001; evt_done twice; en stays 1.
- Clr priority: clr asserted mid-run with a simultaneous sample → no write strobe; en=0 next cycle. Then clr+en in the same cycle → remains IDLE.
- Size 0 / en-while-running: en with size=0 → stays IDLE. en pulsed mid-run → addr/left unaffected.
